sync_ram_clr: RTL

Parametrised synchronous single-port RAM for HC4 data memory, generalising the original 4-bit × 256-nibble asynchronous RAM. It keeps the active-low read/write enable scheme. It replaces the tristate bus with separate write and read data ports and registers all accesses on one clock. It adds configurable read latency, a hardware clear engine (on reset or on request) and detection of illegal read+write commands.

---
 rtl/sync_ram_clr_if.sv | 26 ++
 rtl/sync_ram_clr.sv | 112 +++++++++++
 2 files changed

// File: rtl/sync_ram_clr_if.sv
// Command/response bundle for sync_ram_clr.
// Master drives commands; slave is the RAM.
interface sync_ram_clr_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              nwrite_enable;
    logic              nread_enable;
    logic              clear_req;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              conflict;

    modport master (
        output address, wdata, nwrite_enable, nread_enable, clear_req,
        input  rdata, rvalid, busy, conflict
    );

    modport slave (
        input  address, wdata, nwrite_enable, nread_enable, clear_req,
        output rdata, rvalid, busy, conflict
    );
endinterface

// File: rtl/sync_ram_clr.sv
// Synchronous single-port data RAM with active-low commands,
// 1/2-cycle read latency, zero-fill clear engine and conflict flag.
module sync_ram_clr #(
    parameter int DATA_W         = 4,
    parameter int ADDR_W         = 8,
    parameter int READ_LAT       = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic           clk,
    input logic           rst,
    sync_ram_clr_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              conflict_q, conflict_d;

    logic              idle;
    logic              wr_go;
    logic              rd_go;
    logic              cf_go;
    logic [DATA_W-1:0] rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idle    = (state_q == S_IDLE);
    assign wr_go   = idle && !bus.nwrite_enable && bus.nread_enable;
    assign rd_go   = idle && bus.nwrite_enable && !bus.nread_enable;
    assign cf_go   = idle && !bus.nwrite_enable && !bus.nread_enable;
    assign rd_word = mem[bus.address];

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = bus.address;
        mem_wdata  = bus.wdata;
        unique case (state_q)
            S_CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                mem_we = wr_go;
                if (bus.clear_req) state_d = S_CLEAR;
            end
        endcase
    end

    // Read data is captured at the sampling edge, so in-flight reads
    // still return pre-clear contents.
    always_comb begin
        s1_valid_d = rd_go;
        s1_data_d  = rd_go ? rd_word : s1_data_q;
        conflict_d = cf_go;
        if (READ_LAT == 2) begin
            rvalid_d = s1_valid_q;
            rdata_d  = s1_valid_q ? s1_data_q : rdata_q;
        end else begin
            rvalid_d = rd_go;
            rdata_d  = rd_go ? rd_word : rdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            conflict_q <= conflict_d;
        end
    end

    // Storage has no reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.busy     = (state_q == S_CLEAR);
    assign bus.conflict = conflict_q;
endmodule
